// File: rtl/ysyx_23060059_pkg.sv
// rtl/ysyx_23060059_pkg.sv - shared FSM encodings and response codes for the read arbiter
package ysyx_23060059_pkg;

  // Arbiter FSM states; encoding is fixed so the write-channel copy can share it.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    AR_SEND = 2'd1,
    R_WAIT  = 2'd2,
    R_ERR   = 2'd3
  } arb_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/ysyx_23060059_rd_arbiter.sv
// rtl/ysyx_23060059_rd_arbiter.sv - two-master single-outstanding read-channel arbiter
module ysyx_23060059_rd_arbiter
  import ysyx_23060059_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              busy,
  output logic              owner
);

  localparam bit               TMO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

  arb_state_e       state_q;
  logic             owner_q;
  logic             last_owner_q;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [CNT_W-1:0] tmo_cnt_d;

  logic              own_arvalid;
  logic              own_rready;
  logic [ADDR_W-1:0] own_araddr;

  // Round robin: a lone requester always wins; on a tie the master not served last wins.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
    if (req0 && req1) begin
      return ~last;
    end
    return req1;
  endfunction

  assign own_arvalid = owner_q ? m1_arvalid : m0_arvalid;
  assign own_rready  = owner_q ? m1_rready  : m0_rready;
  assign own_araddr  = owner_q ? m1_araddr  : m0_araddr;
  assign tmo_cnt_d   = tmo_cnt_q + 1'b1;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

  // Arbitration FSM: grant in IDLE, forward AR, wait for R or time out into a forced SLVERR.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      tmo_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (m0_arvalid || m1_arvalid) begin
            owner_q <= rr_pick(m0_arvalid, m1_arvalid, last_owner_q);
            state_q <= AR_SEND;
          end
        end
        AR_SEND: begin
          if (s_arvalid && s_arready) begin
            state_q      <= R_WAIT;
            last_owner_q <= owner_q;
            tmo_cnt_q    <= '0;
          end else if (!own_arvalid) begin
            // Owner withdrew its request before the slave took it: nothing was issued.
            state_q <= IDLE;
          end
        end
        R_WAIT: begin
          if (s_rvalid && s_rready) begin
            state_q <= IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (TMO_EN && (tmo_cnt_q == TMO_LIMIT) && !s_rvalid) begin
              state_q <= R_ERR;
            end
          end
        end
        R_ERR: begin
          if (own_rready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Route the shared slave port to the current owner; the non-owner sees an idle channel.
  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    m0_rresp   = RESP_OKAY;
    m1_rresp   = RESP_OKAY;
    case (state_q)
      AR_SEND: begin
        s_araddr  = own_araddr;
        s_arvalid = own_arvalid;
        if (owner_q) begin
          m1_arready = s_arready;
        end else begin
          m0_arready = s_arready;
        end
      end
      R_WAIT: begin
        s_rready = own_rready;
        if (owner_q) begin
          m1_rvalid = s_rvalid;
          m1_rdata  = s_rdata;
          m1_rresp  = s_rresp;
        end else begin
          m0_rvalid = s_rvalid;
          m0_rdata  = s_rdata;
          m0_rresp  = s_rresp;
        end
      end
      R_ERR: begin
        // Slave never answered: synthesize an error beat; data stays zero.
        if (owner_q) begin
          m1_rvalid = 1'b1;
          m1_rresp  = RESP_SLVERR;
        end else begin
          m0_rvalid = 1'b1;
          m0_rresp  = RESP_SLVERR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060059_rd_arbiter.sv
// tb/tb_ysyx_23060059_rd_arbiter.sv - randomized bench for the read arbiter against a transaction model
module tb_ysyx_23060059_rd_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TMO  = 8;
  localparam int NCYC = 4000;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    arv_i;
  logic [1:0]    rrdy_i;
  logic [AW-1:0] addr_i [2];
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;

  logic          m0_arready, m1_arready, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [1:0]    m0_rresp, m1_rresp;
  logic [AW-1:0] s_araddr;
  logic          s_arvalid, s_rready, busy, owner;

  always #5 clock = ~clock;

  ysyx_23060059_rd_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset),
    .m0_araddr(addr_i[0]), .m0_arvalid(arv_i[0]), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(rrdy_i[0]),
    .m1_araddr(addr_i[1]), .m1_arvalid(arv_i[1]), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(rrdy_i[1]),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .busy(busy), .owner(owner)
  );

  wire [1:0] arr_o = {m1_arready, m0_arready};
  wire [1:0] rv_o  = {m1_rvalid, m0_rvalid};

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Transaction model: phase 0 none, 1 address offered, 2 awaiting data, 3 forced error
  int   ph;
  bit   own, last;
  int   since;
  int   n_tmo, n_tie, n_done;

  // Master agents
  bit            pend  [2];
  bit            waitd [2];
  logic [AW-1:0] maddr [2];
  bit            comp  [2];
  bit            mar_hs[2];

  // Slave agent
  bit            sl_busy, sl_never;
  int            sl_cnt, sl_lat;
  logic [AW-1:0] sl_addr;
  logic [1:0]    sl_resp;
  bit            ar_hs, s_hs;

  task automatic model_reset();
    ph = 0; own = 1'b0; last = 1'b1; since = 0;
    for (int m = 0; m < 2; m++) begin
      pend[m] = 1'b0; waitd[m] = 1'b0;
    end
    sl_busy = 1'b0; sl_cnt = 0;
  endtask

  task automatic drive(input int c);
    int req_pct;
    reset   = (c > 20) && ($urandom_range(0, 149) == 0);
    req_pct = ((c / 500) % 2 == 1) ? 30 : 90;
    for (int m = 0; m < 2; m++) begin
      if (!pend[m] && !waitd[m] && ($urandom_range(0, 99) < req_pct)) begin
        pend[m]  = 1'b1;
        maddr[m] = $urandom() & 32'hFFFF_FFFC;
      end else if (pend[m] && ($urandom_range(0, 31) == 0)) begin
        pend[m] = 1'b0;
      end
      arv_i[m]  = pend[m];
      addr_i[m] = pend[m] ? maddr[m] : $urandom();
      rrdy_i[m] = ($urandom_range(0, 3) != 0);
    end
    s_arready = ($urandom_range(0, 99) < 60);
    s_rvalid  = sl_busy && !sl_never && (sl_cnt >= sl_lat);
    s_rdata   = s_rvalid ? memfn(sl_addr) : $urandom();
    s_rresp   = s_rvalid ? sl_resp : 2'($urandom_range(0, 3));
  endtask

  task automatic compare();
    bit            e_sarv, e_srr;
    logic [AW-1:0] e_saddr;
    logic [1:0]    e_arr, e_rv;
    logic [DW-1:0] e_rd;
    logic [1:0]    e_rr;
    e_sarv = 1'b0; e_srr = 1'b0; e_saddr = '0; e_arr = '0; e_rv = '0; e_rd = '0; e_rr = 2'b00;
    case (ph)
      1: begin
        e_sarv     = arv_i[own];
        e_saddr    = addr_i[own];
        e_arr[own] = s_arready;
      end
      2: begin
        e_srr     = rrdy_i[own];
        e_rv[own] = s_rvalid;
        e_rd      = s_rdata;
        e_rr      = s_rresp;
      end
      3: begin
        e_rv[own] = 1'b1;
        e_rd      = '0;
        e_rr      = 2'b10;
      end
      default: ;
    endcase
    check_eq("busy", busy, (ph != 0));
    check_eq("owner", owner, own);
    check_eq("s_arvalid", s_arvalid, e_sarv);
    if (e_sarv) check_eq("s_araddr", s_araddr, e_saddr);
    check_eq("m0_arready", m0_arready, e_arr[0]);
    check_eq("m1_arready", m1_arready, e_arr[1]);
    check_eq("s_rready", s_rready, e_srr);
    check_eq("m0_rvalid", m0_rvalid, e_rv[0]);
    check_eq("m1_rvalid", m1_rvalid, e_rv[1]);
    if (e_rv[0]) begin
      check_eq("m0_rdata", m0_rdata, e_rd);
      check_eq("m0_rresp", m0_rresp, e_rr);
    end
    if (e_rv[1]) begin
      check_eq("m1_rdata", m1_rdata, e_rd);
      check_eq("m1_rresp", m1_rresp, e_rr);
    end
    // End-to-end scoreboard: the data a master receives must belong to its own address.
    for (int m = 0; m < 2; m++) begin
      logic [DW-1:0] rd_m;
      logic [1:0]    rr_m;
      rd_m    = (m == 1) ? m1_rdata : m0_rdata;
      rr_m    = (m == 1) ? m1_rresp : m0_rresp;
      comp[m] = rv_o[m] && rrdy_i[m];
      mar_hs[m] = arv_i[m] && arr_o[m];
      if (comp[m]) begin
        n_done++;
        check_eq("sb_solicited", waitd[m], 1'b1);
        if (sl_busy && s_rvalid) begin
          check_eq("sb_data", rd_m, memfn(maddr[m]));
          check_eq("sb_resp", rr_m, sl_resp);
        end else begin
          check_eq("sb_err_data", rd_m, 32'h0);
          check_eq("sb_err_resp", rr_m, 2'b10);
        end
      end
    end
    ar_hs = s_arvalid && s_arready;
    s_hs  = s_rvalid && s_rready;
  endtask

  task automatic update();
    logic [AW-1:0] ar_addr;
    ar_addr = s_araddr;
    if (reset) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (comp[m]) waitd[m] = 1'b0;
      if (mar_hs[m]) begin
        pend[m]  = 1'b0;
        waitd[m] = 1'b1;
      end
    end
    if (sl_busy) begin
      if (s_hs) begin
        sl_busy = 1'b0;
      end else begin
        sl_cnt++;
        if (sl_never && sl_cnt > TMO) sl_busy = 1'b0;
      end
    end else if (ar_hs) begin
      sl_busy  = 1'b1;
      sl_cnt   = 0;
      sl_addr  = ar_addr;
      sl_never = ($urandom_range(0, 5) == 0);
      sl_lat   = $urandom_range(0, 5);
      sl_resp  = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
    end
    case (ph)
      0: begin
        if (arv_i != 2'b00) begin
          if (arv_i == 2'b11) begin
            own = !last;
            n_tie++;
          end else begin
            own = arv_i[1];
          end
          ph = 1;
        end
      end
      1: begin
        if (arv_i[own] && s_arready) begin
          ph = 2; last = own; since = 0;
        end else if (!arv_i[own]) begin
          ph = 0;
        end
      end
      2: begin
        if (s_rvalid && rrdy_i[own]) begin
          ph = 0;
        end else begin
          if (since == TMO && !s_rvalid) begin
            ph = 3;
            n_tmo++;
          end
          since++;
        end
      end
      3: if (rrdy_i[own]) ph = 0;
      default: ph = 0;
    endcase
  endtask

  initial begin
    n_tmo = 0; n_tie = 0; n_done = 0;
    reset = 1'b1; arv_i = 2'b00; rrdy_i = 2'b00;
    addr_i[0] = '0; addr_i[1] = '0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_owner", owner, 1'b0);
    check_eq("rst_s_arvalid", s_arvalid, 1'b0);
    check_eq("rst_s_araddr", s_araddr, 32'h0);
    check_eq("rst_s_rready", s_rready, 1'b0);
    check_eq("rst_arready", arr_o, 2'b00);
    check_eq("rst_rvalid", rv_o, 2'b00);
    check_eq("rst_m0_rdata", m0_rdata, 32'h0);
    check_eq("rst_m1_rdata", m1_rdata, 32'h0);
    @(posedge clock);
    #1;
    for (int c = 0; c < NCYC; c++) begin
      cyc = c;
      drive(c);
      @(negedge clock);
      compare();
      @(posedge clock);
      update();
      #1;
    end
    check_eq("cov_timeouts_seen", (n_tmo > 0), 1'b1);
    check_eq("cov_ties_seen", (n_tie > 0), 1'b1);
    check_eq("cov_completions_seen", (n_done > 100), 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
